// File: rtl/ym3438_out_mix.sv
// Stereo output mixer: accumulates panned channel values over a sample frame and
// publishes L/R pairs with a valid strobe. Optional macro YM2612_LADDER_EN adds DAC crossover offset.
module ym3438_out_mix #(
  parameter int ACC_W     = 12,
  parameter int FRAME_LEN = 24
) (
  input  logic                    MCLK,
  input  logic                    IC_b,
  input  logic                    c1,
  input  logic                    c2,
  input  logic                    sample_sync,
  input  logic                    ch_strobe,
  input  logic [8:0]              ch_out,
  input  logic [1:0]              ch_pan,
  output logic signed [ACC_W-1:0] out_l,
  output logic signed [ACC_W-1:0] out_r,
  output logic                    out_valid,
  output logic                    sync_err,
  output logic [4:0]              slot_cnt
);

  localparam logic [4:0] LAST_SLOT = 5'(FRAME_LEN - 1);

  logic signed [ACC_W-1:0] acc_l_q, acc_l_d;
  logic signed [ACC_W-1:0] acc_r_q, acc_r_d;
  logic signed [ACC_W-1:0] out_l_q, out_l_d;
  logic signed [ACC_W-1:0] out_r_q, out_r_d;
  logic                    out_valid_q, out_valid_d;
  logic                    sync_err_q, sync_err_d;
  logic [4:0]              slot_cnt_q, slot_cnt_d;

  logic [8:0]              v;
  logic signed [ACC_W-1:0] vx;
  logic signed [ACC_W-1:0] cl, cr;
  logic                    fs;
  logic                    align_bad;
  logic                    unused_c2;

  assign unused_c2 = c2;

  // Offset binary to two's complement: invert the MSB, then sign-extend.
  assign v  = {~ch_out[8], ch_out[7:0]};
  assign vx = {{(ACC_W-9){v[8]}}, v};

`ifdef YM2612_LADDER_EN
  logic signed [ACC_W-1:0] ofs;
  assign ofs = v[8] ? {{(ACC_W-3){1'b1}}, 3'b100} : {{(ACC_W-3){1'b0}}, 3'b100};

  always_comb begin
    cl = '0;
    cr = '0;
    if (ch_strobe) begin
      cl = ch_pan[1] ? vx + ofs : ofs;
      cr = ch_pan[0] ? vx + ofs : ofs;
    end
  end
`else
  always_comb begin
    cl = '0;
    cr = '0;
    if (ch_strobe) begin
      cl = ch_pan[1] ? vx : '0;
      cr = ch_pan[0] ? vx : '0;
    end
  end
`endif

  assign fs        = sample_sync | (slot_cnt_q == LAST_SLOT);
  assign align_bad = sample_sync && (slot_cnt_q != LAST_SLOT) && (slot_cnt_q != '0);

  always_comb begin
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    out_valid_d = 1'b0;
    sync_err_d  = sync_err_q;
    slot_cnt_d  = slot_cnt_q;
    if (c1) begin
      if (fs) begin
        // Closing slot's own value seeds the next frame rather than this one.
        out_l_d     = acc_l_q;
        out_r_d     = acc_r_q;
        acc_l_d     = cl;
        acc_r_d     = cr;
        slot_cnt_d  = '0;
        out_valid_d = 1'b1;
      end else begin
        acc_l_d    = acc_l_q + cl;
        acc_r_d    = acc_r_q + cr;
        slot_cnt_d = slot_cnt_q + 5'd1;
      end
      if (align_bad) sync_err_d = 1'b1;
    end
  end

  always_ff @(posedge MCLK or negedge IC_b) begin
    if (!IC_b) begin
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      slot_cnt_q  <= '0;
    end else begin
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      slot_cnt_q  <= slot_cnt_d;
    end
  end

  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign slot_cnt  = slot_cnt_q;

endmodule
